// File: rtl/contador_ascendente_if.sv
// Control/status bundle for the up-counting timer.
// The master drives start/carga/pausa/clear; the slave (the timer) returns its count and status.
interface contador_ascendente_if #(
    parameter int N = 4
) ();
    logic         start;
    logic [N-1:0] carga;
    logic         pausa;
    logic         clear;
    logic [N-1:0] cuenta;
    logic         ocupado;
    logic         listo;
    logic         fin;

    modport master (
        output start, carga, pausa, clear,
        input  cuenta, ocupado, listo, fin
    );

    modport slave (
        input  start, carga, pausa, clear,
        output cuenta, ocupado, listo, fin
    );
endinterface

// File: rtl/contador_ascendente.sv
// Up-counting timer: latches a target on start and counts from 0 to it,
// one increment every PRESCALE clocks, with pause, abort and a one-cycle fin pulse.
//
//   state  | meaning
//   IDLE   | waiting for start, count held
//   RUN    | prescaler advancing, count incrementing
//   PAUSED | count and prescaler frozen while pausa is high
//   DONE   | count equals target, listo high, fin pulses on entry
module contador_ascendente #(
    parameter int N        = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clock,
    input  logic               reset,
    contador_ascendente_if.slave bus
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [N-1:0]  cuenta_q;
    logic [N-1:0]  target;
    logic [PW-1:0] pres;
    logic          ocupado_q;
    logic          listo_q;
    logic          fin_q;
    logic [N-1:0]  cuenta_inc;

    // cuenta never exceeds target, so this increment cannot wrap in practice
    assign cuenta_inc = cuenta_q + N'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cuenta_q  <= '0;
            target    <= '0;
            pres      <= '0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (bus.clear) begin
                state     <= IDLE;
                cuenta_q  <= '0;
                pres      <= '0;
                ocupado_q <= 1'b0;
                listo_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            target   <= bus.carga;
                            cuenta_q <= '0;
                            pres     <= '0;
                            if (bus.carga == '0) begin
                                state     <= DONE;
                                ocupado_q <= 1'b0;
                                listo_q   <= 1'b1;
                                fin_q     <= 1'b1;
                            end else begin
                                state     <= RUN;
                                ocupado_q <= 1'b1;
                                listo_q   <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.pausa) begin
                            state <= PAUSED;
                        end else if (pres == PS_LAST) begin
                            pres     <= '0;
                            cuenta_q <= cuenta_inc;
                            if (cuenta_inc == target) begin
                                state     <= DONE;
                                ocupado_q <= 1'b0;
                                listo_q   <= 1'b1;
                                fin_q     <= 1'b1;
                            end
                        end else begin
                            pres <= pres + PW'(1);
                        end
                    end
                    PAUSED: begin
                        // the edge that leaves PAUSED does not count; counting resumes on the next one
                        if (!bus.pausa) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cuenta  = cuenta_q;
    assign bus.ocupado = ocupado_q;
    assign bus.listo   = listo_q;
    assign bus.fin     = fin_q;
endmodule

// File: tb/tb_contador_ascendente.sv
// Directed bench for contador_ascendente: one DUT with PRESCALE=1, one with PRESCALE=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_contador_ascendente;
    logic clock = 1'b0;
    logic reset;
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    contador_ascendente_if #(.N(4)) bus_a ();
    contador_ascendente_if #(.N(4)) bus_b ();

    contador_ascendente #(.N(4), .PRESCALE(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    contador_ascendente #(.N(4), .PRESCALE(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.start = 0; bus_a.carga = '0; bus_a.pausa = 0; bus_a.clear = 0;
        bus_b.start = 0; bus_b.carga = '0; bus_b.pausa = 0; bus_b.clear = 0;
        #2;
        checks++;
        if ({bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin} !== 7'd0) begin
            failures++;
            $display("FAIL reset_a: got cuenta=%0d ocupado=%b listo=%b fin=%b, want all 0",
                     bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin);
        end
        checks++;
        if ({bus_b.cuenta, bus_b.ocupado, bus_b.listo, bus_b.fin} !== 7'd0) begin
            failures++;
            $display("FAIL reset_b: got cuenta=%0d ocupado=%b listo=%b fin=%b, want all 0",
                     bus_b.cuenta, bus_b.ocupado, bus_b.listo, bus_b.fin);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int ocup_cnt;
        int fin_cnt;
        bus_a.carga = 4'd5; bus_a.start = 1;
        step();
        bus_a.start = 0; bus_a.carga = 4'd9;
        checks++;
        if (bus_a.cuenta !== 4'd0 || bus_a.ocupado !== 1'b1) begin
            failures++;
            $display("FAIL basic_accept: cuenta=%0d ocupado=%b, want 0/1", bus_a.cuenta, bus_a.ocupado);
        end
        ocup_cnt = 1;
        fin_cnt  = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (bus_a.ocupado === 1'b1) ocup_cnt++;
            if (bus_a.fin === 1'b1) fin_cnt++;
            checks++;
            if (bus_a.cuenta !== 4'(i) || bus_a.listo !== (i == 5) || bus_a.fin !== (i == 5)) begin
                failures++;
                $display("FAIL basic_count[%0d]: cuenta=%0d listo=%b fin=%b, want %0d/%b/%b",
                         i, bus_a.cuenta, bus_a.listo, bus_a.fin, i, (i == 5), (i == 5));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus_a.fin === 1'b1) fin_cnt++;
            checks++;
            if (bus_a.cuenta !== 4'd5 || bus_a.listo !== 1'b1 || bus_a.ocupado !== 1'b0) begin
                failures++;
                $display("FAIL basic_hold[%0d]: cuenta=%0d listo=%b ocupado=%b, want 5/1/0",
                         i, bus_a.cuenta, bus_a.listo, bus_a.ocupado);
            end
        end
        checks++;
        if (ocup_cnt != 5 || fin_cnt != 1) begin
            failures++;
            $display("FAIL basic_pulse_len: ocupado cycles=%0d fin cycles=%0d, want 5/1", ocup_cnt, fin_cnt);
        end
    endtask

    task automatic test_zero();
        bus_a.carga = 4'd0; bus_a.start = 1;
        step();
        bus_a.start = 0;
        checks++;
        if (bus_a.cuenta !== 4'd0 || bus_a.ocupado !== 1'b0 || bus_a.listo !== 1'b1 || bus_a.fin !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: cuenta=%0d ocupado=%b listo=%b fin=%b, want 0/0/1/1",
                     bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin);
        end
        step();
        checks++;
        if (bus_a.fin !== 1'b0 || bus_a.listo !== 1'b1 || bus_a.ocupado !== 1'b0) begin
            failures++;
            $display("FAIL zero_hold: fin=%b listo=%b ocupado=%b, want 0/1/0", bus_a.fin, bus_a.listo, bus_a.ocupado);
        end
    endtask

    task automatic test_max();
        int bad;
        bus_a.carga = 4'd15; bus_a.start = 1;
        step();
        bus_a.start = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (bus_a.cuenta !== 4'(i) || bus_a.ocupado !== (i < 15)) begin
                failures++;
                $display("FAIL max_count[%0d]: cuenta=%0d ocupado=%b, want %0d/%b", i, bus_a.cuenta, bus_a.ocupado, i, (i < 15));
            end
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_a.cuenta !== 4'd15 || bus_a.listo !== 1'b1 || bus_a.fin !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL max_hold: %0d of 20 cycles left 15/listo, want 0 (last cuenta=%0d)", bad, bus_a.cuenta);
        end
    endtask

    task automatic test_pause();
        bus_a.carga = 4'd6; bus_a.start = 1;
        step();                                 // edge k
        bus_a.start = 0;
        step(); step();                         // k+1, k+2
        checks++;
        if (bus_a.cuenta !== 4'd2) begin
            failures++;
            $display("FAIL pause_pre: cuenta=%0d, want 2", bus_a.cuenta);
        end
        bus_a.pausa = 1;
        for (int i = 3; i <= 5; i++) begin
            if (i == 5) bus_a.pausa = 0;
            step();
            checks++;
            if (bus_a.cuenta !== 4'd2 || bus_a.ocupado !== 1'b1) begin
                failures++;
                $display("FAIL pause_freeze[k+%0d]: cuenta=%0d ocupado=%b, want 2/1", i, bus_a.cuenta, bus_a.ocupado);
            end
            if (i == 3) bus_a.pausa = 1;
        end
        for (int i = 6; i <= 9; i++) begin
            step();
            checks++;
            if (bus_a.cuenta !== 4'(i - 3) || bus_a.listo !== (i == 9) || bus_a.fin !== (i == 9)) begin
                failures++;
                $display("FAIL pause_resume[k+%0d]: cuenta=%0d listo=%b fin=%b, want %0d/%b/%b",
                         i, bus_a.cuenta, bus_a.listo, bus_a.fin, i - 3, (i == 9), (i == 9));
            end
        end
    endtask

    task automatic test_prescale();
        logic [3:0] exp_a [0:7];
        logic [3:0] exp_b [0:8];
        exp_a = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
        bus_b.carga = 4'd2; bus_b.start = 1;
        step();
        bus_b.start = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) step();
            else step();
            checks++;
            if (bus_b.cuenta !== exp_a[i] || bus_b.fin !== (i == 6) || bus_b.listo !== (i >= 6)) begin
                failures++;
                $display("FAIL prescale[k+%0d]: cuenta=%0d fin=%b listo=%b, want %0d/%b/%b",
                         i, bus_b.cuenta, bus_b.fin, bus_b.listo, exp_a[i], (i == 6), (i >= 6));
            end
        end
        // restart from DONE with a pause during prescaler phase 1: two edges lost
        exp_b = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        bus_b.carga = 4'd2; bus_b.start = 1;
        step();
        bus_b.start = 0;
        for (int i = 1; i <= 8; i++) begin
            bus_b.pausa = (i == 2);
            step();
            checks++;
            if (bus_b.cuenta !== exp_b[i] || bus_b.listo !== (i == 8) || bus_b.ocupado !== (i < 8)) begin
                failures++;
                $display("FAIL prescale_pause[k+%0d]: cuenta=%0d listo=%b ocupado=%b, want %0d/%b/%b",
                         i, bus_b.cuenta, bus_b.listo, bus_b.ocupado, exp_b[i], (i == 8), (i < 8));
            end
        end
        bus_b.pausa = 0;
    endtask

    task automatic test_abort();
        // async reset mid-count
        bus_a.carga = 4'd9; bus_a.start = 1;
        step();
        bus_a.start = 0;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin} !== 7'd0) begin
            failures++;
            $display("FAIL async_reset: cuenta=%0d ocupado=%b listo=%b fin=%b, want all 0",
                     bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin);
        end
        #1 reset = 1'b0;
        step();
        checks++;
        if ({bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin} !== 7'd0) begin
            failures++;
            $display("FAIL reset_after: cuenta=%0d ocupado=%b listo=%b fin=%b, want all 0",
                     bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin);
        end
        // clear at cuenta=3
        bus_a.carga = 4'd9; bus_a.start = 1;
        step();
        bus_a.start = 0;
        step(); step(); step();
        checks++;
        if (bus_a.cuenta !== 4'd3) begin
            failures++;
            $display("FAIL clear_pre: cuenta=%0d, want 3", bus_a.cuenta);
        end
        bus_a.clear = 1;
        step();
        bus_a.clear = 0;
        checks++;
        if ({bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin} !== 7'd0) begin
            failures++;
            $display("FAIL clear_idle: cuenta=%0d ocupado=%b listo=%b fin=%b, want all 0",
                     bus_a.cuenta, bus_a.ocupado, bus_a.listo, bus_a.fin);
        end
        step();
        checks++;
        if (bus_a.cuenta !== 4'd0 || bus_a.ocupado !== 1'b0) begin
            failures++;
            $display("FAIL clear_hold: cuenta=%0d ocupado=%b, want 0/0", bus_a.cuenta, bus_a.ocupado);
        end
        // start and clear on the same edge
        bus_a.carga = 4'd4; bus_a.start = 1; bus_a.clear = 1;
        step();
        bus_a.start = 0; bus_a.clear = 0;
        step();
        checks++;
        if (bus_a.cuenta !== 4'd0 || bus_a.ocupado !== 1'b0 || bus_a.listo !== 1'b0) begin
            failures++;
            $display("FAIL start_clear: cuenta=%0d ocupado=%b listo=%b, want 0/0/0", bus_a.cuenta, bus_a.ocupado, bus_a.listo);
        end
    endtask

    task automatic test_back_to_back();
        bus_a.carga = 4'd2; bus_a.start = 1;
        step();
        bus_a.start = 0;
        step(); step();
        checks++;
        if (bus_a.cuenta !== 4'd2 || bus_a.listo !== 1'b1 || bus_a.fin !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: cuenta=%0d listo=%b fin=%b, want 2/1/1", bus_a.cuenta, bus_a.listo, bus_a.fin);
        end
        bus_a.carga = 4'd3; bus_a.start = 1;
        step();
        bus_a.start = 0;
        checks++;
        if (bus_a.cuenta !== 4'd0 || bus_a.listo !== 1'b0 || bus_a.ocupado !== 1'b1 || bus_a.fin !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: cuenta=%0d listo=%b ocupado=%b fin=%b, want 0/0/1/0",
                     bus_a.cuenta, bus_a.listo, bus_a.ocupado, bus_a.fin);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus_a.cuenta !== 4'((i > 3) ? 3 : i) || bus_a.fin !== (i == 3)) begin
                failures++;
                $display("FAIL b2b_count[%0d]: cuenta=%0d fin=%b, want %0d/%b",
                         i, bus_a.cuenta, bus_a.fin, (i > 3) ? 3 : i, (i == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_pause();
        test_prescale();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
